// File: rtl/isolator_serial_ctrl.sv
// Sequencer for the isolator board's 74xx shift-register chain: a free-running frame
// shifts per-slot config out, shifts slot status in, and latches both on srclk.
module isolator_serial_ctrl #(
    parameter int CLK_DIV = 2,
    parameter int NBITS   = 8
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [3:0] dmcs_cfg_i,
    input  logic [3:0] amcs_cfg_i,
    input  logic [3:0] clksel_cfg_i,
    input  logic [3:0] aovf_clr_i,
    output logic       mclk_o,
    output logic       srclk_o,
    output logic       dmcs_o,
    output logic       amcs_o,
    output logic       clksel_o,
    input  logic       dirchan_i,
    input  logic       aovf_i,
    output logic [3:0] slot_dir_o,
    output logic [3:0] slot_chan_o,
    output logic [3:0] aovfl_sticky_o,
    output logic [3:0] aovfr_sticky_o,
    output logic       status_valid_o,
    output logic       cfg_applied_o
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(NBITS);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

    typedef enum logic {
        ST_SHIFT,
        ST_LATCH
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic            phase_q, phase_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [11:0]     snap_q, snap_d;
    logic            mclk_q, mclk_d;
    logic            srclk_q, srclk_d;
    logic            dmcs_q, dmcs_d;
    logic            amcs_q, amcs_d;
    logic            clksel_q, clksel_d;
    logic [NBITS-1:0] dir_sr_q, dir_sr_d;
    logic [NBITS-1:0] ovf_sr_q, ovf_sr_d;
    logic [3:0]      slot_dir_q, slot_dir_d;
    logic [3:0]      slot_chan_q, slot_chan_d;
    logic [3:0]      aovfl_q, aovfl_d;
    logic [3:0]      aovfr_q, aovfr_d;
    logic            valid_q, valid_d;
    logic            seen_latch_q, seen_latch_d;
    logic            cfg_applied_q, cfg_applied_d;
    logic            tick;
    logic [11:0]     cfg_now;

    // Out-word is {zeros, slot bits}, sent MSB first; k is the bit position in send order.
    function automatic logic word_bit(input logic [3:0] s, input logic [BW-1:0] k);
        logic [NBITS-1:0] w;
        w = {{(NBITS-4){1'b0}}, s};
        return w[BIT_LAST - k];
    endfunction

    assign tick    = (div_q == DIV_LAST);
    assign cfg_now = {dmcs_cfg_i, amcs_cfg_i, clksel_cfg_i};

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= ST_SHIFT;
            div_q         <= '0;
            phase_q       <= 1'b0;
            bit_q         <= '0;
            snap_q        <= '0;
            mclk_q        <= 1'b0;
            srclk_q       <= 1'b0;
            dmcs_q        <= 1'b0;
            amcs_q        <= 1'b0;
            clksel_q      <= 1'b0;
            dir_sr_q      <= '0;
            ovf_sr_q      <= '0;
            slot_dir_q    <= '0;
            slot_chan_q   <= '0;
            aovfl_q       <= '0;
            aovfr_q       <= '0;
            valid_q       <= 1'b0;
            seen_latch_q  <= 1'b0;
            cfg_applied_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            phase_q       <= phase_d;
            bit_q         <= bit_d;
            snap_q        <= snap_d;
            mclk_q        <= mclk_d;
            srclk_q       <= srclk_d;
            dmcs_q        <= dmcs_d;
            amcs_q        <= amcs_d;
            clksel_q      <= clksel_d;
            dir_sr_q      <= dir_sr_d;
            ovf_sr_q      <= ovf_sr_d;
            slot_dir_q    <= slot_dir_d;
            slot_chan_q   <= slot_chan_d;
            aovfl_q       <= aovfl_d;
            aovfr_q       <= aovfr_d;
            valid_q       <= valid_d;
            seen_latch_q  <= seen_latch_d;
            cfg_applied_q <= cfg_applied_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        div_d         = tick ? '0 : div_q + 1'b1;
        phase_d       = phase_q;
        bit_d         = bit_q;
        snap_d        = snap_q;
        mclk_d        = mclk_q;
        srclk_d       = srclk_q;
        dmcs_d        = dmcs_q;
        amcs_d        = amcs_q;
        clksel_d      = clksel_q;
        dir_sr_d      = dir_sr_q;
        ovf_sr_d      = ovf_sr_q;
        slot_dir_d    = slot_dir_q;
        slot_chan_d   = slot_chan_q;
        aovfl_d       = aovfl_q & ~aovf_clr_i;
        aovfr_d       = aovfr_q & ~aovf_clr_i;
        valid_d       = valid_q;
        seen_latch_d  = seen_latch_q;
        cfg_applied_d = 1'b0;

        if (tick) begin
            phase_d = ~phase_q;
            unique case (state_q)
                ST_SHIFT: begin
                    if (!phase_q) begin
                        mclk_d   = 1'b1;
                        dir_sr_d = {dir_sr_q[NBITS-2:0], dirchan_i};
                        ovf_sr_d = {ovf_sr_q[NBITS-2:0], aovf_i};
                    end else begin
                        mclk_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_d = ST_LATCH;
                            srclk_d = 1'b1;
                            bit_d   = '0;
                            // The first frame after reset shifts in whatever the board held at power-up.
                            if (seen_latch_q) begin
                                slot_chan_d = dir_sr_q[7:4];
                                slot_dir_d  = dir_sr_q[3:0];
                                aovfl_d     = aovfl_d | {ovf_sr_q[6], ovf_sr_q[4], ovf_sr_q[2], ovf_sr_q[0]};
                                aovfr_d     = aovfr_d | {ovf_sr_q[7], ovf_sr_q[5], ovf_sr_q[3], ovf_sr_q[1]};
                                valid_d     = 1'b1;
                            end
                        end else begin
                            bit_d    = bit_q + 1'b1;
                            dmcs_d   = word_bit(snap_q[11:8], bit_q + 1'b1);
                            amcs_d   = word_bit(snap_q[7:4], bit_q + 1'b1);
                            clksel_d = word_bit(snap_q[3:0], bit_q + 1'b1);
                        end
                    end
                end
                ST_LATCH: begin
                    if (phase_q) begin
                        state_d       = ST_SHIFT;
                        srclk_d       = 1'b0;
                        seen_latch_d  = 1'b1;
                        cfg_applied_d = 1'b1;
                        snap_d        = cfg_now;
                        dmcs_d        = word_bit(cfg_now[11:8], '0);
                        amcs_d        = word_bit(cfg_now[7:4], '0);
                        clksel_d      = word_bit(cfg_now[3:0], '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mclk_o         = mclk_q;
    assign srclk_o        = srclk_q;
    assign dmcs_o         = dmcs_q;
    assign amcs_o         = amcs_q;
    assign clksel_o       = clksel_q;
    assign slot_dir_o     = slot_dir_q;
    assign slot_chan_o    = slot_chan_q;
    assign aovfl_sticky_o = aovfl_q;
    assign aovfr_sticky_o = aovfr_q;
    assign status_valid_o = valid_q;
    assign cfg_applied_o  = cfg_applied_q;

endmodule
